// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the L1/L2 arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } lc3b_arb_state;

    // Encoding of the last_grant register.
    localparam logic ARB_GRANT_I = 1'b0;
    localparam logic ARB_GRANT_D = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module arb_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the I-side and D-side L1 caches; the grant is
// held until l2_mem_resp, and grant/conflict activity is counted.
module l1_l2_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  lc3b_word             i_mem_address,
    input  lc3b_c_line           i_mem_wdata,
    output logic                 i_mem_resp,
    output lc3b_c_line           i_mem_rdata,

    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  lc3b_word             d_mem_address,
    input  lc3b_c_line           d_mem_wdata,
    output logic                 d_mem_resp,
    output lc3b_c_line           d_mem_rdata,

    output logic                 l2_mem_read,
    output logic                 l2_mem_write,
    output lc3b_word             l2_mem_address,
    output lc3b_c_line           l2_mem_wdata,
    input  logic                 l2_mem_resp,
    input  lc3b_c_line           l2_mem_rdata,

    output logic [CNT_WIDTH-1:0] i_grant_count,
    output logic [CNT_WIDTH-1:0] d_grant_count,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    lc3b_arb_state state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          req_i, req_d;
    logic          i_grant_inc, d_grant_inc, conflict_inc;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_grant_inc  = 1'b0;
        d_grant_inc  = 1'b0;
        conflict_inc = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                conflict_inc = req_i & req_d;
                // On conflict D wins in fixed mode, else the side not granted last.
                if (req_d && (!req_i || (PRIORITY_MODE != 0) || (last_grant_q == ARB_GRANT_I))) begin
                    state_d      = ARB_SERVE_D;
                    last_grant_d = ARB_GRANT_D;
                    d_grant_inc  = 1'b1;
                end else if (req_i) begin
                    state_d      = ARB_SERVE_I;
                    last_grant_d = ARB_GRANT_I;
                    i_grant_inc  = 1'b1;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (l2_mem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        l2_mem_read    = 1'b0;
        l2_mem_write   = 1'b0;
        l2_mem_address = '0;
        l2_mem_wdata   = '0;
        i_mem_resp     = 1'b0;
        d_mem_resp     = 1'b0;
        case (state_q)
            ARB_SERVE_I: begin
                l2_mem_read    = i_mem_read;
                l2_mem_write   = i_mem_write;
                l2_mem_address = i_mem_address;
                l2_mem_wdata   = i_mem_wdata;
                i_mem_resp     = l2_mem_resp;
            end
            ARB_SERVE_D: begin
                l2_mem_read    = d_mem_read;
                l2_mem_write   = d_mem_write;
                l2_mem_address = d_mem_address;
                l2_mem_wdata   = d_mem_wdata;
                d_mem_resp     = l2_mem_resp;
            end
            default: ;
        endcase
    end

    assign i_mem_rdata = l2_mem_rdata;
    assign d_mem_rdata = l2_mem_rdata;

    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_i_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_grant_inc),
        .count (i_grant_count)
    );

    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_d_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_grant_inc),
        .count (d_grant_count)
    );

    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict_inc),
        .count (conflict_count)
    );

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench: dut0 is round-robin/16-bit counters, dut1 is
// fixed-priority with 2-bit counters so saturation is reachable quickly.
module tb_l1_l2_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       i_rd[2], i_wr[2], d_rd[2], d_wr[2], l2_resp[2];
    lc3b_word   i_addr[2], d_addr[2], l2_addr[2];
    lc3b_c_line i_wd[2], d_wd[2], l2_rdat[2], l2_wd[2], i_rdat[2], d_rdat[2];
    logic       i_resp[2], d_resp[2], l2_rd[2], l2_wr[2];
    logic [15:0] ic0, dc0, cc0;
    logic [1:0]  ic1, dc1, cc1;

    l1_l2_arbiter #(.PRIORITY_MODE(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst),
        .i_mem_read(i_rd[0]), .i_mem_write(i_wr[0]), .i_mem_address(i_addr[0]),
        .i_mem_wdata(i_wd[0]), .i_mem_resp(i_resp[0]), .i_mem_rdata(i_rdat[0]),
        .d_mem_read(d_rd[0]), .d_mem_write(d_wr[0]), .d_mem_address(d_addr[0]),
        .d_mem_wdata(d_wd[0]), .d_mem_resp(d_resp[0]), .d_mem_rdata(d_rdat[0]),
        .l2_mem_read(l2_rd[0]), .l2_mem_write(l2_wr[0]), .l2_mem_address(l2_addr[0]),
        .l2_mem_wdata(l2_wd[0]), .l2_mem_resp(l2_resp[0]), .l2_mem_rdata(l2_rdat[0]),
        .i_grant_count(ic0), .d_grant_count(dc0), .conflict_count(cc0)
    );

    l1_l2_arbiter #(.PRIORITY_MODE(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst),
        .i_mem_read(i_rd[1]), .i_mem_write(i_wr[1]), .i_mem_address(i_addr[1]),
        .i_mem_wdata(i_wd[1]), .i_mem_resp(i_resp[1]), .i_mem_rdata(i_rdat[1]),
        .d_mem_read(d_rd[1]), .d_mem_write(d_wr[1]), .d_mem_address(d_addr[1]),
        .d_mem_wdata(d_wd[1]), .d_mem_resp(d_resp[1]), .d_mem_rdata(d_rdat[1]),
        .l2_mem_read(l2_rd[1]), .l2_mem_write(l2_wr[1]), .l2_mem_address(l2_addr[1]),
        .l2_mem_wdata(l2_wd[1]), .l2_mem_resp(l2_resp[1]), .l2_mem_rdata(l2_rdat[1]),
        .i_grant_count(ic1), .d_grant_count(dc1), .conflict_count(cc1)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        lc3b_word   addr;
        lc3b_c_line wd;
        logic       side_d;
    } txn_t;

    typedef struct {
        logic     ir, iw, dr, dw;
        logic     grant, side_d, exp_rd, exp_wr;
        lc3b_word exp_addr;
    } vec_t;

    txn_t sb[$];
    int passed = 0;
    int total  = 0;

    localparam lc3b_c_line LINE_A = {8{16'hA5A5}};
    localparam lc3b_c_line LINE_B = {8{16'h5B5B}};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 0; i_wr[k] = 0; d_rd[k] = 0; d_wr[k] = 0; l2_resp[k] = 0;
            i_addr[k] = '0; d_addr[k] = '0; i_wd[k] = '0; d_wd[k] = '0; l2_rdat[k] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        sb.delete();
    endtask

    task automatic set_i(input int idx, input logic rd, input logic wr, input lc3b_word a,
                         input lc3b_c_line w);
        i_rd[idx] = rd; i_wr[idx] = wr; i_addr[idx] = a; i_wd[idx] = w;
    endtask

    task automatic set_d(input int idx, input logic rd, input logic wr, input lc3b_word a,
                         input lc3b_c_line w);
        d_rd[idx] = rd; d_wr[idx] = wr; d_addr[idx] = a; d_wd[idx] = w;
    endtask

    task automatic push(input logic rd, input logic wr, input lc3b_word a, input lc3b_c_line w,
                        input logic side_d);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.wd = w; t.side_d = side_d;
        sb.push_back(t);
    endtask

    // L2 model: wait for a command, compare with scoreboard head, respond after lat cycles.
    task automatic serve(input int idx, input int lat, input lc3b_c_line line);
        int   n;
        txn_t e;
        n = 0;
        while (!(l2_rd[idx] | l2_wr[idx]) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20 || sb.size() == 0) begin
            total++;
            $display("FAIL serve_wait: got no command or no expectation (queue=%0d)", sb.size());
            return;
        end
        e = sb.pop_front();
        chk("l2_read", l2_rd[idx], e.rd);
        chk("l2_write", l2_wr[idx], e.wr);
        chk("l2_addr", l2_addr[idx], e.addr);
        chk("l2_wdata", l2_wd[idx], e.wd);
        repeat (lat) step();
        l2_rdat[idx] = line;
        l2_resp[idx] = 1'b1;
        #1;
        chk("i_resp", i_resp[idx], !e.side_d);
        chk("d_resp", d_resp[idx], e.side_d);
        chk("rdata", e.side_d ? d_rdat[idx] : i_rdat[idx], line);
        step();
        l2_resp[idx] = 1'b0;
        l2_rdat[idx] = '0;
        if (e.side_d) set_d(idx, 0, 0, '0, '0);
        else          set_i(idx, 0, 0, '0, '0);
    endtask

    vec_t vecs[8];

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("rst_l2_read", l2_rd[0], 1'b0);
        chk("rst_l2_addr", l2_addr[0], 16'h0);

        // Fresh-reset arbitration table on dut0 (last_grant = I).
        vecs[0] = '{0,0,0,0, 0,0,0,0, 16'h0000};
        vecs[1] = '{1,0,0,0, 1,0,1,0, 16'h1111};
        vecs[2] = '{0,1,0,0, 1,0,0,1, 16'h1111};
        vecs[3] = '{0,0,1,0, 1,1,1,0, 16'h2222};
        vecs[4] = '{0,0,0,1, 1,1,0,1, 16'h2222};
        vecs[5] = '{1,0,1,0, 1,1,1,0, 16'h2222};
        vecs[6] = '{1,1,0,0, 1,0,1,1, 16'h1111};
        vecs[7] = '{0,1,1,0, 1,1,1,0, 16'h2222};
        for (int v = 0; v < 8; v++) begin
            do_reset();
            chk("reset_counts", {ic0, dc0, cc0}, 48'h0);
            set_i(0, vecs[v].ir, vecs[v].iw, 16'h1111, LINE_A);
            set_d(0, vecs[v].dr, vecs[v].dw, 16'h2222, LINE_B);
            step();
            chk("tbl_l2_read", l2_rd[0], vecs[v].exp_rd);
            chk("tbl_l2_write", l2_wr[0], vecs[v].exp_wr);
            chk("tbl_l2_addr", l2_addr[0], vecs[v].exp_addr);
            chk("tbl_l2_wdata", l2_wd[0],
                !vecs[v].grant ? 128'h0 : (vecs[v].side_d ? LINE_B : LINE_A));
            if (vecs[v].grant) begin
                l2_resp[0] = 1'b1;
                #1;
                chk("tbl_i_resp", i_resp[0], !vecs[v].side_d);
                chk("tbl_d_resp", d_resp[0], vecs[v].side_d);
                step();
                l2_resp[0] = 1'b0;
            end
        end

        // 1: I read, L2 answers 3 cycles later.
        do_reset();
        set_i(0, 1, 0, 16'h1230, '0);
        push(1, 0, 16'h1230, '0, 0);
        chk("t1_idle_before", l2_rd[0], 1'b0);
        step();
        chk("t1_read_cycle1", l2_rd[0], 1'b1);
        serve(0, 3, {8{16'hAAAA}});
        chk("t1_i_grants", ic0, 16'd1);
        chk("t1_d_grants", dc0, 16'd0);

        // 2: simultaneous I read / D write, round-robin: D first.
        do_reset();
        set_i(0, 1, 0, 16'h0040, '0);
        set_d(0, 0, 1, 16'h8000, LINE_B);
        push(0, 1, 16'h8000, LINE_B, 1);
        push(1, 0, 16'h0040, '0, 0);
        serve(0, 1, LINE_A);
        serve(0, 2, LINE_B);
        chk("t2_conflicts", cc0, 16'd1);
        chk("t2_grants", {ic0, dc0}, {16'd1, 16'd1});

        // 4: D writeback then read with I requesting -> D, I, D.
        do_reset();
        set_i(0, 1, 0, 16'h0040, '0);
        set_d(0, 0, 1, 16'h9F00, LINE_A);
        push(0, 1, 16'h9F00, LINE_A, 1);
        serve(0, 0, '0);
        set_d(0, 1, 0, 16'h1200, '0);
        push(1, 0, 16'h0040, '0, 0);
        push(1, 0, 16'h1200, '0, 1);
        serve(0, 0, LINE_B);
        set_i(0, 1, 0, 16'h0040, '0);
        serve(0, 1, LINE_A);
        chk("t4_conflicts", cc0, 16'd3);
        chk("t4_grants", {ic0, dc0}, {16'd1, 16'd2});
        set_i(0, 0, 0, '0, '0);

        // 5: reset during SERVE_I aborts the grant; late resp is dropped.
        do_reset();
        set_i(0, 1, 0, 16'h1230, '0);
        step();
        chk("t5_serving", l2_rd[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_abort_read", l2_rd[0], 1'b0);
        chk("t5_abort_addr", l2_addr[0], 16'h0);
        chk("t5_abort_count", ic0, 16'd0);
        set_i(0, 0, 0, '0, '0);
        step();
        rst = 1'b0;
        step();
        l2_resp[0] = 1'b1;
        #1;
        chk("t5_late_i_resp", i_resp[0], 1'b0);
        chk("t5_late_d_resp", d_resp[0], 1'b0);
        l2_resp[0] = 1'b0;

        // 3: fixed priority, D re-requests back-to-back and starves I.
        do_reset();
        set_i(1, 1, 0, 16'h0040, '0);
        for (int r = 0; r < 3; r++) begin
            set_d(1, 0, 1, 16'h8000 + 16'(r), LINE_B);
            push(0, 1, 16'h8000 + 16'(r), LINE_B, 1);
            serve(1, 1, '0);
        end
        chk("t3_d_grants", dc1, 2'd3);
        chk("t3_i_starved", ic1, 2'd0);
        chk("t3_conflicts", cc1, 2'd3);

        // 6: two more D grants under conflict; 2-bit counters stay at all-ones.
        for (int r = 0; r < 2; r++) begin
            set_d(1, 1, 0, 16'h0100 + 16'(r), '0);
            push(1, 0, 16'h0100 + 16'(r), '0, 1);
            serve(1, 0, LINE_A);
        end
        chk("t6_d_sat", dc1, 2'd3);
        chk("t6_conf_sat", cc1, 2'd3);
        push(1, 0, 16'h0040, '0, 0);
        serve(1, 0, LINE_B);
        chk("t6_i_grant", ic1, 2'd1);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L2 cache port between the instruction-side L1 and the data-side L1.
- Each L1 presents a cache-line request: read, write or writeback of an lc3b_c_line. The arbiter grants one requester, holds the grant until l2_mem_resp, then returns the response to that requester only.
- Sits between the two L1 instances and the L2. Also provides saturating performance counters for grants and conflicts.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin on conflict; 1 = fixed priority, D-side always wins.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_mem_read  in  1  I-side L1 line read request.
- i_mem_write  in  1  I-side L1 line write request.
- i_mem_address  in  16 (lc3b_word)  I-side line address.
- i_mem_wdata  in  128 (lc3b_c_line)  I-side write line.
- i_mem_resp  out  1  response to I-side.
- i_mem_rdata  out  128  read line to I-side.
- d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_resp, d_mem_rdata: D-side equivalents, same directions and widths.
- l2_mem_read  out  1  read command to L2.
- l2_mem_write  out  1  write command to L2.
- l2_mem_address  out  16  address to L2.
- l2_mem_wdata  out  128  write line to L2.
- l2_mem_resp  in  1  L2 completion, single-cycle pulse.
- l2_mem_rdata  in  128  L2 read line, valid when l2_mem_resp=1.
- i_grant_count  out  CNT_WIDTH  I-side grants issued.
- d_grant_count  out  CNT_WIDTH  D-side grants issued.
- conflict_count  out  CNT_WIDTH  cycles in IDLE with both sides requesting.

Behaviour:
- Request definitions: req_i = i_mem_read|i_mem_write; req_d = d_mem_read|d_mem_write.
- FSM states: IDLE, SERVE_I, SERVE_D. State is registered; reset state is IDLE.
- IDLE transitions:
  - Only req_i -> SERVE_I.
  - Only req_d -> SERVE_D.
  - Both requesting, PRIORITY_MODE=1 -> SERVE_D.
  - Both requesting, PRIORITY_MODE=0 -> the side not equal to last_grant.
  - No request -> stay in IDLE.
- last_grant: 1-bit register, updated on entry to SERVE_x. Reset value = I, so the first conflict after reset goes to D.
- SERVE_x:
  - l2_mem_read/write/address/wdata are driven combinationally from requester x's inputs. Commands pass through unmodified, including read and write asserted together (protocol violation, not filtered).
  - On l2_mem_resp=1: x_mem_resp=1 in the same cycle, and the FSM goes to IDLE at the next edge.
  - Otherwise remain in SERVE_x. The grant is held even if requester x drops its request early (violation); the L2 operation is allowed to complete.
- In IDLE: all l2_mem_* command outputs are 0; address and wdata are 0.
- Response gating:
  - i_mem_resp = l2_mem_resp & (state==SERVE_I).
  - d_mem_resp = l2_mem_resp & (state==SERVE_D).
  - An l2_mem_resp arriving in IDLE is dropped.
- i_mem_rdata and d_mem_rdata = l2_mem_rdata unconditionally; only resp qualifies them.
- Latency:
  - Request sampled in IDLE at edge N -> L2 command visible from cycle N+1.
  - Minimum arbitration overhead is 1 cycle per transaction. A requester that re-requests immediately after its resp is re-arbitrated in the following IDLE cycle.
- L1 miss with dirty victim: writeback then read appear as two separate requests. The other side may be granted between them under round-robin; this is legal.
- Counters:
  - i_grant_count / d_grant_count increment on each IDLE->SERVE_x transition.
  - conflict_count increments on each IDLE cycle with req_i&req_d.
  - All counters saturate at all-ones and never wrap.
- Reset:
  - All outputs are 0 during and after reset; FSM=IDLE; counters=0; last_grant=I.
  - Reset mid-transaction aborts the grant immediately (asynchronous). An in-flight L2 op is the L2's responsibility; it is reset by the same rst.

Decomposition:
- lc3b_types (shared package) holds lc3b_word, lc3b_c_line, and a new enum lc3b_arb_state {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
- One natural sub-module: arb_sat_counter (parameter WIDTH; ports inc, count; async reset), instanced three times.
- Mux and FSM stay in l1_l2_arbiter.

Test Plan:
1. Reset, then I-side read only to 0x1230; L2 responds 3 cycles later with line 0xAAAA...
   - l2_mem_read=1 with addr 0x1230 from cycle 1.
   - i_mem_resp=1 with rdata 0xAAAA... in the resp cycle; d_mem_resp=0.
   - i_grant_count=1.
2. Simultaneous I read 0x0040 and D write 0x8000, PRIORITY_MODE=0, fresh reset:
   - D served first (l2_mem_write=1, addr 0x8000), then I.
   - conflict_count=1, then increments again if I is still waiting when IDLE samples.
3. Same as 2 with PRIORITY_MODE=1 and D re-requesting 3 times back-to-back -> D is granted every time and I is starved; d_grant_count=3.
4. D writeback to 0x9F00 then read to 0x1200 with I continuously requesting, mode 0 -> grant order D, I, D.
5. Assert rst during SERVE_I before resp -> all l2_mem_* are 0 immediately, FSM=IDLE, counters=0; a late l2_mem_resp produces no i/d resp.
6. Preload counters to all-ones -> further grants leave the count at all-ones.
